// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  // Redirect sequencing: normal flow or holding a redirect toward the PC stage.
  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } ctrl_state_e;

  // Multi-cycle divider occupancy of the EX stage.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Stage indices into ready_go / flush.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_div_seq.sv
// Divider stall sequencer: holds EX for DIV_LAT-1 cycles, releasing on cycle DIV_LAT.
module pipe_hazard_ctrl_div_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 8
) (
  input  logic aclk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic mem_allow_in,
  output logic ex_hold,
  output logic div_busy
);

  localparam int CNT_W = ($clog2(DIV_LAT) > 4) ? $clog2(DIV_LAT) : 4;

  div_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  // State and counter registers; an abort (WB event) always lands in IDLE.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next state and EX hold. The start cycle counts as the first held cycle,
  // so BUSY lasts DIV_LAT-2 cycles and DONE is the release cycle.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    ex_hold   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ex_hold = 1'b1;
          cnt_nxt = CNT_W'(DIV_LAT - 2);
          if (DIV_LAT == 2) state_nxt = DONE;
          else              state_nxt = BUSY;
        end
      end
      BUSY: begin
        ex_hold = 1'b1;
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (mem_allow_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  assign div_busy = (state_q != IDLE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage ready_go/flush, load-use and divider
// stalls, and a held PC redirect for branch mispredicts and WB events.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 8,
  parameter int PC_W    = 32
) (
  input  logic            aclk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [4:0]      id_rj,
  input  logic [4:0]      id_rk,
  input  logic            id_use_rj,
  input  logic            id_use_rk,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic            ex_is_div,
  input  logic [4:0]      ex_rd,
  input  logic            mem_allow_in,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            wb_valid,
  input  logic            wb_exc,
  input  logic            wb_ertn,
  input  logic            wb_refetch,
  input  logic [PC_W-1:0] exc_entry,
  input  logic [PC_W-1:0] era,
  input  logic [PC_W-1:0] wb_pc,
  input  logic            if_allow_in,
  output logic [4:0]      ready_go,
  output logic [3:0]      flush,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            div_busy
);

  // WB redirect target with priority exc > ertn > refetch (wraps modulo 2^PC_W).
  function automatic logic [PC_W-1:0] wb_target(input logic            exc,
                                                input logic            ertn,
                                                input logic [PC_W-1:0] entry,
                                                input logic [PC_W-1:0] ret,
                                                input logic [PC_W-1:0] pc);
    if (exc)       return entry;
    else if (ertn) return ret;
    else           return pc + PC_W'(4);
  endfunction

  ctrl_state_e     ctrl_q, ctrl_nxt;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_nxt;
  logic            exc_ev, br_ev, load_use, ex_hold;

  assign exc_ev = wb_valid & (wb_exc | wb_ertn | wb_refetch);
  assign br_ev  = ex_valid & br_taken & ~exc_ev;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((id_use_rj & (id_rj == ex_rd)) | (id_use_rk & (id_rk == ex_rd)));

  pipe_hazard_ctrl_div_seq #(
    .DIV_LAT (DIV_LAT)
  ) u_div_seq (
    .aclk         (aclk),
    .reset        (reset),
    .start        (ex_valid & ex_is_div),
    .abort        (exc_ev),
    .mem_allow_in (mem_allow_in),
    .ex_hold      (ex_hold),
    .div_busy     (div_busy)
  );

  // Redirect state and held target; a pending redirect is dropped on reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      ctrl_q        <= RUN;
      redirect_pc_q <= '0;
    end else begin
      ctrl_q        <= ctrl_nxt;
      redirect_pc_q <= redirect_pc_nxt;
    end
  end

  // WB events always win and may retarget a pending redirect; branches only
  // start a redirect from RUN, since in REDIR they are on the wrong path.
  always_comb begin
    ctrl_nxt        = ctrl_q;
    redirect_pc_nxt = redirect_pc_q;
    flush           = 4'b0000;
    if (exc_ev) begin
      flush           = 4'b1111;
      ctrl_nxt        = REDIR;
      redirect_pc_nxt = wb_target(wb_exc, wb_ertn, exc_entry, era, wb_pc);
    end else if (ctrl_q == RUN && br_ev) begin
      flush           = 4'b0011;
      ctrl_nxt        = REDIR;
      redirect_pc_nxt = br_target;
    end else if (ctrl_q == REDIR && if_allow_in) begin
      ctrl_nxt = RUN;
    end
  end

  always_comb begin
    ready_go          = 5'b11111;
    ready_go[STG_ID]  = ~load_use;
    ready_go[STG_EX]  = ~ex_hold;
  end

  assign redirect_valid = (ctrl_q == REDIR);
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (DIV_LAT=8, PC_W=32).
module tb_pipe_hazard_ctrl;

  localparam int DIV_LAT = 8;
  localparam int PC_W    = 32;

  logic            aclk, reset;
  logic            id_valid, id_use_rj, id_use_rk;
  logic [4:0]      id_rj, id_rk, ex_rd;
  logic            ex_valid, ex_is_load, ex_is_div, mem_allow_in;
  logic            br_taken, wb_valid, wb_exc, wb_ertn, wb_refetch, if_allow_in;
  logic [PC_W-1:0] br_target, exc_entry, era, wb_pc;
  logic [4:0]      ready_go;
  logic [3:0]      flush;
  logic            redirect_valid, div_busy;
  logic [PC_W-1:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .PC_W(PC_W)) dut (
    .aclk(aclk), .reset(reset),
    .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
    .id_use_rj(id_use_rj), .id_use_rk(id_use_rk),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_is_div(ex_is_div), .ex_rd(ex_rd),
    .mem_allow_in(mem_allow_in), .br_taken(br_taken), .br_target(br_target),
    .wb_valid(wb_valid), .wb_exc(wb_exc), .wb_ertn(wb_ertn), .wb_refetch(wb_refetch),
    .exc_entry(exc_entry), .era(era), .wb_pc(wb_pc), .if_allow_in(if_allow_in),
    .ready_go(ready_go), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .div_busy(div_busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Inputs change 1 ns after the edge; checks are made 1 ns later, mid-cycle.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; id_valid = 0; id_rj = 0; id_rk = 0; id_use_rj = 0; id_use_rk = 0;
    ex_valid = 0; ex_is_load = 0; ex_is_div = 0; ex_rd = 0; mem_allow_in = 1;
    br_taken = 0; br_target = 0; wb_valid = 0; wb_exc = 0; wb_ertn = 0; wb_refetch = 0;
    exc_entry = 0; era = 0; wb_pc = 0; if_allow_in = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
    n_checks++;
    if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
    n_checks++;
    if (flush !== 4'b0000) begin n_fail++; $display("FAIL reset_flush: got %b want 0000", flush); end
    n_checks++;
    if (div_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", div_busy); end
    n_checks++;
    if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL reset_rg: got %b want 11111", ready_go); end
    reset = 0;
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_rj = 5; id_use_rj = 1;
    #1;
    n_checks++;
    if (ready_go !== 5'b11101) begin n_fail++; $display("FAIL lu_rj: got %b want 11101", ready_go); end
    id_rj = 3; id_use_rj = 1; id_rk = 5; id_use_rk = 1;
    #1;
    n_checks++;
    if (ready_go !== 5'b11101) begin n_fail++; $display("FAIL lu_rk: got %b want 11101", ready_go); end
    id_use_rk = 0;
    #1;
    n_checks++;
    if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL lu_unused: got %b want 11111", ready_go); end
    ex_rd = 0; id_rj = 0; id_use_rj = 1;
    #1;
    n_checks++;
    if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL lu_r0: got %b want 11111", ready_go); end
    ex_rd = 5; id_rj = 5; ex_is_load = 0;
    #1;
    n_checks++;
    if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL lu_noload: got %b want 11111", ready_go); end
    clear_inputs();
    tick();
  endtask

  task automatic test_divide();
    logic exp_rg2, exp_busy;
    clear_inputs();
    ex_valid = 1; ex_is_div = 1; mem_allow_in = 1;
    for (int i = 1; i <= DIV_LAT; i++) begin
      #1;
      exp_rg2  = (i == DIV_LAT);
      exp_busy = (i != 1);
      n_checks++;
      if (ready_go[2] !== exp_rg2) begin n_fail++; $display("FAIL div_rg2_c%0d: got %b want %b", i, ready_go[2], exp_rg2); end
      n_checks++;
      if (div_busy !== exp_busy) begin n_fail++; $display("FAIL div_busy_c%0d: got %b want %b", i, div_busy, exp_busy); end
      tick();
    end
    ex_valid = 0; ex_is_div = 0;
    #1;
    n_checks++;
    if (div_busy !== 1'b0) begin n_fail++; $display("FAIL div_busy_after: got %b want 0", div_busy); end
    n_checks++;
    if (ready_go !== 5'b11111) begin n_fail++; $display("FAIL div_rg_after: got %b want 11111", ready_go); end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    ex_valid = 1; br_taken = 1; br_target = 32'h1c000100; if_allow_in = 0;
    #1;
    n_checks++;
    if (flush !== 4'b0011) begin n_fail++; $display("FAIL br_flush: got %b want 0011", flush); end
    tick();
    ex_valid = 0; br_taken = 0;
    for (int i = 0; i < 3; i++) begin
      if_allow_in = (i == 2);
      #1;
      n_checks++;
      if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL br_rv_c%0d: got %b want 1", i, redirect_valid); end
      n_checks++;
      if (redirect_pc !== 32'h1c000100) begin n_fail++; $display("FAIL br_pc_c%0d: got %h want 1c000100", i, redirect_pc); end
      n_checks++;
      if (flush !== 4'b0000) begin n_fail++; $display("FAIL br_flush_c%0d: got %b want 0000", i, flush); end
      tick();
    end
    if_allow_in = 0;
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL br_run: got %b want 0", redirect_valid); end
    tick();
  endtask

  task automatic test_exc_priority();
    clear_inputs();
    wb_valid = 1; wb_exc = 1; exc_entry = 32'h1c008000;
    ex_valid = 1; br_taken = 1; br_target = 32'h1c000100;
    #1;
    n_checks++;
    if (flush !== 4'b1111) begin n_fail++; $display("FAIL exbr_flush: got %b want 1111", flush); end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_pc !== 32'h1c008000) begin n_fail++; $display("FAIL exbr_pc: got %h want 1c008000", redirect_pc); end
    n_checks++;
    if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL exbr_rv: got %b want 1", redirect_valid); end
    // ertn outranks refetch
    wb_valid = 1; wb_ertn = 1; wb_refetch = 1; era = 32'h1c000444; wb_pc = 32'h1c000990;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_pc !== 32'h1c000444) begin n_fail++; $display("FAIL ertn_pc: got %h want 1c000444", redirect_pc); end
    // refetch wraps around
    wb_valid = 1; wb_refetch = 1; wb_pc = 32'hFFFFFFFC;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL refetch_wrap: got %h want 0", redirect_pc); end
    n_checks++;
    if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL refetch_rv: got %b want 1", redirect_valid); end
    if_allow_in = 1;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL refetch_done: got %b want 0", redirect_valid); end
    tick();
  endtask

  task automatic test_exc_during_div();
    clear_inputs();
    ex_valid = 1; ex_is_div = 1; mem_allow_in = 1;
    tick();
    tick();
    tick();
    #1;
    n_checks++;
    if (div_busy !== 1'b1) begin n_fail++; $display("FAIL exdiv_busy_pre: got %b want 1", div_busy); end
    ex_valid = 0; ex_is_div = 0;
    wb_valid = 1; wb_exc = 1; exc_entry = 32'h1c00a000;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (div_busy !== 1'b0) begin n_fail++; $display("FAIL exdiv_busy: got %b want 0", div_busy); end
    n_checks++;
    if (ready_go[2] !== 1'b1) begin n_fail++; $display("FAIL exdiv_rg2: got %b want 1", ready_go[2]); end
    n_checks++;
    if (redirect_pc !== 32'h1c00a000) begin n_fail++; $display("FAIL exdiv_pc: got %h want 1c00a000", redirect_pc); end
    if_allow_in = 1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ex_valid = 1; br_taken = 1; br_target = 32'h1c000200;
    tick();
    clear_inputs();
    // a branch seen in REDIR must not retarget
    ex_valid = 1; br_taken = 1; br_target = 32'h1c000300;
    #1;
    n_checks++;
    if (flush !== 4'b0000) begin n_fail++; $display("FAIL redir_br_flush: got %b want 0000", flush); end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_pc !== 32'h1c000200) begin n_fail++; $display("FAIL redir_br_ignored: got %h want 1c000200", redirect_pc); end
    wb_valid = 1; wb_exc = 1; exc_entry = 32'h1c008000;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_pc !== 32'h1c008000) begin n_fail++; $display("FAIL redir_exc_pc: got %h want 1c008000", redirect_pc); end
    // accept and new event in the same cycle: stay in REDIR with the new target
    if_allow_in = 1; wb_valid = 1; wb_exc = 1; exc_entry = 32'h1c00c000;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL acc_exc_rv: got %b want 1", redirect_valid); end
    n_checks++;
    if (redirect_pc !== 32'h1c00c000) begin n_fail++; $display("FAIL acc_exc_pc: got %h want 1c00c000", redirect_pc); end
    // reset while a redirect is pending drops it
    reset = 1;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_redir_rv: got %b want 0", redirect_valid); end
    n_checks++;
    if (flush !== 4'b0000) begin n_fail++; $display("FAIL rst_redir_flush: got %b want 0000", flush); end
    n_checks++;
    if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_redir_pc: got %h want 0", redirect_pc); end
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_divide();
    test_branch();
    test_exc_priority();
    test_exc_during_div();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
